// File: rtl/spi_ctrl_pkg.sv
// Shared codes, widths and bus payload types for the SPI command sequencer.
package spi_ctrl_pkg;

    localparam int unsigned BITS_SPI     = 32;
    localparam int unsigned NUM_BUFBYTES = 10;
    localparam int unsigned RST_CYCLES   = 16;
    localparam int unsigned BITS_TO      = 20;
    localparam int unsigned BITS_RC      = $clog2(RST_CYCLES);
    localparam int unsigned BITS_ADDR    = 4;

    localparam int unsigned POS_CMD   = 28;
    localparam int unsigned POS_ADDR  = 24;
    localparam int unsigned POS_WDATA = 8;
    localparam int unsigned POS_TAG   = 0;

    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_DUMMY        = 4'd1,
        ST_REG_SET      = 4'd2,
        ST_REG_GET      = 4'd3,
        ST_RESET_DLY    = 4'd4,
        ST_RESET_PIXEL  = 4'd5,
        ST_RESET_ANALOG = 4'd6,
        ST_DLY_CALIB    = 4'd8,
        ST_PIXEL_CALIB  = 4'd9,
        ST_MAIN_WORK    = 4'd10,
        ST_ERR          = 4'd15
    } state_t;

    localparam logic [3:0] CMD_DUMMY        = 4'd1;
    localparam logic [3:0] CMD_REG_SET      = 4'd2;
    localparam logic [3:0] CMD_REG_GET      = 4'd3;
    localparam logic [3:0] CMD_RESET_DLY    = 4'd4;
    localparam logic [3:0] CMD_RESET_PIXEL  = 4'd5;
    localparam logic [3:0] CMD_RESET_ANALOG = 4'd6;
    localparam logic [3:0] CMD_DLY_CALIB    = 4'd8;
    localparam logic [3:0] CMD_PIXEL_CALIB  = 4'd9;
    localparam logic [3:0] CMD_MAIN_WORK    = 4'd10;

    localparam logic [3:0] ERR_NONE    = 4'd0;
    localparam logic [3:0] ERR_CMD     = 4'd1;
    localparam logic [3:0] ERR_ADDR    = 4'd2;
    localparam logic [3:0] ERR_BUSY    = 4'd3;
    localparam logic [3:0] ERR_TIMEOUT = 4'd4;

    typedef struct packed {
        logic [3:0] cmd;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [3:0] tag;
    } frame_t;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] cmd;
        logic [3:0] err;
        logic [3:0] tag;
        logic [7:0] rdata;
        logic [7:0] rej;
    } reply_t;

    function automatic logic is_known_cmd(input logic [3:0] c);
        case (c)
            CMD_DUMMY, CMD_REG_SET, CMD_REG_GET, CMD_RESET_DLY, CMD_RESET_PIXEL,
            CMD_RESET_ANALOG, CMD_DLY_CALIB, CMD_PIXEL_CALIB, CMD_MAIN_WORK: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spi_frame_sync.sv
// Synchronises the SPI busy flag, detects end of frame and filters repeated or empty frames.
module spi_frame_sync
    import spi_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n_spi,
    input  logic [BITS_SPI-1:0] spi_word_i,
    input  logic                spi_busy_i,
    output logic                frame_valid,
    output frame_t              frame
);

    logic   busy_s1, busy_s2, busy_q, tag_valid;
    logic   frame_done_c, accept_c;
    frame_t word_c;
    logic   unused_bits;

    always_comb begin
        word_c.cmd   = spi_word_i[POS_CMD +: 4];
        word_c.addr  = spi_word_i[POS_ADDR +: 4];
        word_c.wdata = spi_word_i[POS_WDATA +: 8];
        word_c.tag   = spi_word_i[POS_TAG +: 4];
    end

    assign unused_bits  = ^{spi_word_i[23:16], spi_word_i[7:4]};
    assign frame_done_c = busy_q & ~busy_s2;
    // frame.tag always holds the last accepted tag, so it doubles as the repeat filter
    assign accept_c     = frame_done_c && (word_c.cmd != 4'd0)
                          && !(tag_valid && (word_c.tag == frame.tag));

    always_ff @(posedge clk or negedge rst_n_spi) begin
        if (!rst_n_spi) begin
            busy_s1     <= 1'b0;
            busy_s2     <= 1'b0;
            busy_q      <= 1'b0;
            tag_valid   <= 1'b0;
            frame_valid <= 1'b0;
            frame       <= '0;
        end else begin
            busy_s1     <= spi_busy_i;
            busy_s2     <= busy_s1;
            busy_q      <= busy_s2;
            frame_valid <= accept_c;
            if (accept_c) begin
                frame     <= word_c;
                tag_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer: decodes host frames, owns the config bytes and sequences sub-blocks.
module spi_cmd_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = (1 << BITS_TO) - 1
) (
    input  logic                      clk,
    input  logic                      rst_n_spi,
    input  logic [BITS_SPI-1:0]       spi_word_i,
    input  logic                      spi_busy_i,
    output logic [BITS_SPI-1:0]       spi_reply_o,
    output logic [3:0]                state_o,
    output logic [8*NUM_BUFBYTES-1:0] cfg_o,
    output logic                      rst_dly_o,
    output logic                      rst_pixel_o,
    output logic                      rst_analog_o,
    output logic                      dly_calib_start_o,
    output logic                      pixel_calib_start_o,
    output logic                      main_start_o,
    output logic                      main_stop_o,
    input  logic                      dly_calib_done_i,
    input  logic                      pixel_calib_done_i,
    input  logic                      main_done_i
);

    logic   frame_valid;
    frame_t frame;

    spi_frame_sync u_frame_sync (
        .clk         (clk),
        .rst_n_spi   (rst_n_spi),
        .spi_word_i  (spi_word_i),
        .spi_busy_i  (spi_busy_i),
        .frame_valid (frame_valid),
        .frame       (frame)
    );

    state_t                             state, state_n;
    logic [NUM_BUFBYTES-1:0][7:0]       cfg, cfg_n;
    logic [3:0]                         err_code, err_n, last_cmd, last_cmd_n;
    logic [7:0]                         rdata, rdata_n, rej_cnt, rej_n;
    logic [BITS_RC-1:0]                 rcnt, rcnt_n;
    logic [BITS_TO-1:0]                 wd, wd_n;
    logic                               pend_q, pend_n, stop_n;
    logic                               frm_c, busy_frm_c, timeout_c, in_range_c, done_c;

    always_ff @(posedge clk or negedge rst_n_spi) begin
        if (!rst_n_spi) begin
            state               <= ST_IDLE;
            cfg                 <= '0;
            err_code            <= ERR_NONE;
            last_cmd            <= 4'd0;
            rdata               <= 8'd0;
            rej_cnt             <= 8'd0;
            rcnt                <= '0;
            wd                  <= '0;
            pend_q              <= 1'b0;
            spi_reply_o         <= '0;
            rst_dly_o           <= 1'b0;
            rst_pixel_o         <= 1'b0;
            rst_analog_o        <= 1'b0;
            dly_calib_start_o   <= 1'b0;
            pixel_calib_start_o <= 1'b0;
            main_start_o        <= 1'b0;
            main_stop_o         <= 1'b0;
        end else begin
            state               <= state_n;
            cfg                 <= cfg_n;
            err_code            <= err_n;
            last_cmd            <= last_cmd_n;
            rdata               <= rdata_n;
            rej_cnt             <= rej_n;
            rcnt                <= rcnt_n;
            wd                  <= wd_n;
            pend_q              <= pend_n;
            rst_dly_o           <= (state_n == ST_RESET_DLY);
            rst_pixel_o         <= (state_n == ST_RESET_PIXEL);
            rst_analog_o        <= (state_n == ST_RESET_ANALOG);
            dly_calib_start_o   <= (state_n == ST_DLY_CALIB) && (state != ST_DLY_CALIB);
            pixel_calib_start_o <= (state_n == ST_PIXEL_CALIB) && (state != ST_PIXEL_CALIB);
            main_start_o        <= (state_n == ST_MAIN_WORK) && (state != ST_MAIN_WORK);
            main_stop_o         <= stop_n;
            if (frm_c || (state_n != state)) begin
                spi_reply_o <= reply_t'{st: state_n, cmd: last_cmd_n, err: err_n,
                                        tag: frame.tag, rdata: rdata_n, rej: rej_n};
            end
        end
    end

    // Next state and datapath; a frame arriving as a busy state exits is deferred to IDLE
    always_comb begin
        state_n    = state;
        cfg_n      = cfg;
        err_n      = err_code;
        last_cmd_n = last_cmd;
        rdata_n    = rdata;
        rej_n      = rej_cnt;
        rcnt_n     = '0;
        wd_n       = '0;
        pend_n     = 1'b0;
        stop_n     = 1'b0;
        busy_frm_c = 1'b0;
        timeout_c  = 1'b0;
        done_c     = 1'b0;
        frm_c      = frame_valid | pend_q;
        in_range_c = frame.addr < BITS_ADDR'(NUM_BUFBYTES);

        unique case (state)
            ST_IDLE: begin
                if (frm_c) begin
                    last_cmd_n = frame.cmd;
                    if (is_known_cmd(frame.cmd)) begin
                        state_n = state_t'(frame.cmd);
                    end else begin
                        state_n = ST_ERR;
                        err_n   = ERR_CMD;
                    end
                end
            end
            ST_DUMMY: begin
                state_n = ST_IDLE;
                pend_n  = frm_c;
            end
            ST_REG_SET: begin
                if (in_range_c) begin
                    cfg_n[frame.addr] = frame.wdata;
                    rdata_n           = frame.wdata;
                    err_n             = ERR_NONE;
                end else begin
                    err_n = ERR_ADDR;
                end
                state_n = ST_IDLE;
                pend_n  = frm_c;
            end
            ST_REG_GET: begin
                if (in_range_c) begin
                    rdata_n = cfg[frame.addr];
                    err_n   = ERR_NONE;
                end else begin
                    rdata_n = 8'd0;
                    err_n   = ERR_ADDR;
                end
                state_n = ST_IDLE;
                pend_n  = frm_c;
            end
            ST_RESET_DLY, ST_RESET_PIXEL, ST_RESET_ANALOG: begin
                if (rcnt == BITS_RC'(RST_CYCLES - 1)) begin
                    state_n = ST_IDLE;
                    pend_n  = frm_c;
                end else begin
                    rcnt_n     = rcnt + 1'b1;
                    busy_frm_c = frm_c;
                end
            end
            ST_DLY_CALIB, ST_PIXEL_CALIB: begin
                wd_n   = wd + 1'b1;
                done_c = (state == ST_DLY_CALIB) ? dly_calib_done_i : pixel_calib_done_i;
                if (done_c) begin
                    state_n = ST_IDLE;
                    pend_n  = frm_c;
                end else begin
                    busy_frm_c = frm_c;
                    timeout_c  = (wd == BITS_TO'(TIMEOUT_CYCLES));
                end
            end
            ST_MAIN_WORK: begin
                if (main_done_i) begin
                    state_n = ST_IDLE;
                    pend_n  = frm_c;
                end else if (frm_c && (frame.cmd == CMD_DUMMY) && (frame.wdata == 8'hFF)) begin
                    last_cmd_n = frame.cmd;
                    stop_n     = 1'b1;
                    state_n    = ST_IDLE;
                end else begin
                    busy_frm_c = frm_c;
                end
            end
            ST_ERR: begin
                if (frm_c) begin
                    last_cmd_n = frame.cmd;
                    if (frame.cmd == CMD_DUMMY) begin
                        state_n = ST_IDLE;
                        err_n   = ERR_NONE;
                    end else begin
                        rej_n = sat_inc(rej_cnt);
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (busy_frm_c) begin
            last_cmd_n = frame.cmd;
            if (frame.cmd != CMD_DUMMY) begin
                err_n = ERR_BUSY;
                rej_n = sat_inc(rej_cnt);
            end
        end
        if (timeout_c) begin
            state_n = ST_ERR;
            err_n   = ERR_TIMEOUT;
        end
    end

    assign state_o = state;
    assign cfg_o   = cfg;

endmodule
